// File: rtl/counter_bank.sv
//-----------------------------------------------------------------------------
// counter_bank
//
// Purpose:
//   Bank of NUM_CH independent up/down counters that share one step operand.
//   Each channel supports synchronous clear, synchronous load and counting up
//   or down by 'step'. Overflow is handled either by wrapping or by
//   saturating, as selected by sat_mode. Each channel keeps sticky overflow
//   and underflow flags. This block replaces the older single-channel
//   increment/clear counter and is meant for event and statistics counting in
//   datapath blocks.
//
// Parameters:
//   NUM_CH  number of independent counter channels (>= 1)
//   WIDTH   counter width in bits (>= 2)
//   STEP_W  width of the shared step operand (1..WIDTH)
//
// Ports:
//   aclk        in   clock, all state updates on the rising edge
//   srst        in   synchronous active-high reset, overrides every other input
//   sat_mode    in   0: wrap-around, 1: saturate at 0 / 2^WIDTH-1
//   step        in   shared increment/decrement amount (zero-extended)
//   clr         in   per-channel clear of the counter value
//   load        in   per-channel load of the matching load_val slice
//   load_val    in   load data, channel i at [i*WIDTH +: WIDTH]
//   inc         in   per-channel count up by step
//   dec         in   per-channel count down by step
//   flag_clr    in   per-channel clear of the sticky ovf/unf flags
//   thresh      in   shared threshold, only used with COUNTER_BANK_THRESH_EN
//   out         out  counter values, channel i at [i*WIDTH +: WIDTH]
//   ovf         out  sticky overflow flags
//   unf         out  sticky underflow flags
//   thresh_hit  out  one-cycle pulse when a channel crosses up to >= thresh
//
// Configuration macro:
//   COUNTER_BANK_THRESH_EN
//     Defined:     thresh_hit[i] pulses for one cycle when channel i's value
//                  goes from below thresh to at-or-above thresh.
//     Not defined: thresh is ignored, thresh_hit is tied low and no
//                  comparators are built.
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
//-----------------------------------------------------------------------------
module counter_bank #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic                      aclk,
   input  logic                      srst,
   input  logic                      sat_mode,
   input  logic [STEP_W-1:0]         step,
   input  logic [NUM_CH-1:0]         clr,
   input  logic [NUM_CH-1:0]         load,
   input  logic [NUM_CH*WIDTH-1:0]   load_val,
   input  logic [NUM_CH-1:0]         inc,
   input  logic [NUM_CH-1:0]         dec,
   input  logic [NUM_CH-1:0]         flag_clr,
   input  logic [WIDTH-1:0]          thresh,
   output logic [NUM_CH*WIDTH-1:0]   out,
   output logic [NUM_CH-1:0]         ovf,
   output logic [NUM_CH-1:0]         unf,
   output logic [NUM_CH-1:0]         thresh_hit
);

   localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

   // The step is widened by one bit beyond the counter so that the top bit
   // of every sum/difference is the carry (count up) or borrow (count down).
   logic [WIDTH:0] step_ext;

   assign step_ext = {{(WIDTH+1-STEP_W){1'b0}}, step};

`ifndef COUNTER_BANK_THRESH_EN
   // Without the threshold feature the input is intentionally left unused;
   // folding it into one bit keeps the unused-port intent explicit.
   logic unused_thresh;

   assign unused_thresh = ^thresh;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

      logic [WIDTH-1:0] cnt_q;
      logic [WIDTH-1:0] cnt_next;
      logic [WIDTH:0]   sum;
      logic [WIDTH:0]   diff;
      logic             ovf_evt;
      logic             unf_evt;
      logic             ovf_q;
      logic             unf_q;
      logic             count_up;
      logic             count_down;

      assign sum  = {1'b0, cnt_q} + step_ext;
      assign diff = {1'b0, cnt_q} - step_ext;

      // inc and dec together cancel out, so each direction only counts when
      // it is requested on its own.
      assign count_up   = inc[i] & ~dec[i];
      assign count_down = dec[i] & ~inc[i];

      // Next-value selection with priority clr > load > count. Overflow and
      // underflow events are only raised by an actual count; a clear or a
      // load never touches the flags. A zero step can never carry or borrow,
      // so it holds the value without any special case.
      always_comb begin
         cnt_next = cnt_q;
         ovf_evt  = 1'b0;
         unf_evt  = 1'b0;
         if (clr[i]) begin
            cnt_next = '0;
         end else if (load[i]) begin
            cnt_next = load_val[i*WIDTH +: WIDTH];
         end else if (count_up) begin
            if (sum[WIDTH]) begin
               ovf_evt  = 1'b1;
               cnt_next = sat_mode ? MAX_VAL : sum[WIDTH-1:0];
            end else begin
               cnt_next = sum[WIDTH-1:0];
            end
         end else if (count_down) begin
            if (diff[WIDTH]) begin
               unf_evt  = 1'b1;
               cnt_next = sat_mode ? '0 : diff[WIDTH-1:0];
            end else begin
               cnt_next = diff[WIDTH-1:0];
            end
         end
      end

      // Counter and sticky flag registers. A new event in the same cycle as
      // flag_clr leaves the flag set, so no event is ever lost.
      always_ff @(posedge aclk) begin
         if (srst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            cnt_q <= cnt_next;
            ovf_q <= ovf_evt | (ovf_q & ~flag_clr[i]);
            unf_q <= unf_evt | (unf_q & ~flag_clr[i]);
         end
      end

      assign out[i*WIDTH +: WIDTH] = cnt_q;
      assign ovf[i]                = ovf_q;
      assign unf[i]                = unf_q;

`ifdef COUNTER_BANK_THRESH_EN
      logic hit_q;

      // The crossing is detected on the transition into the register, so the
      // pulse appears on the same cycle as the new value. Comparing the
      // current value against the next one means a value that stays above
      // the threshold never pulses again, and a clear (next value 0) can
      // never satisfy the upward crossing.
      always_ff @(posedge aclk) begin
         if (srst) begin
            hit_q <= 1'b0;
         end else begin
            hit_q <= (cnt_q < thresh) && (cnt_next >= thresh);
         end
      end

      assign thresh_hit[i] = hit_q;
`else
      assign thresh_hit[i] = 1'b0;
`endif

   end

endmodule

// File: tb/tb_counter_bank.sv
//-----------------------------------------------------------------------------
// tb_counter_bank
//
// Self-checking bench for counter_bank (NUM_CH=4, WIDTH=8, STEP_W=4).
// A behavioural model keeps every channel as a plain integer and applies the
// counting rules with ordinary arithmetic; directed scenarios and a random
// run are checked against it and against hand-derived constants.
//-----------------------------------------------------------------------------
module tb_counter_bank;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;
   localparam int MAXV   = (1 << WIDTH) - 1;

   logic                      aclk;
   logic                      srst;
   logic                      sat_mode;
   logic [STEP_W-1:0]         step;
   logic [NUM_CH-1:0]         clr;
   logic [NUM_CH-1:0]         load;
   logic [NUM_CH*WIDTH-1:0]   load_val;
   logic [NUM_CH-1:0]         inc;
   logic [NUM_CH-1:0]         dec;
   logic [NUM_CH-1:0]         flag_clr;
   logic [WIDTH-1:0]          thresh;
   logic [NUM_CH*WIDTH-1:0]   out;
   logic [NUM_CH-1:0]         ovf;
   logic [NUM_CH-1:0]         unf;
   logic [NUM_CH-1:0]         thresh_hit;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_val [NUM_CH];
   bit m_ovf [NUM_CH];
   bit m_unf [NUM_CH];
   bit m_hit [NUM_CH];

   counter_bank #(
      .NUM_CH (NUM_CH),
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) dut (
      .aclk       (aclk),
      .srst       (srst),
      .sat_mode   (sat_mode),
      .step       (step),
      .clr        (clr),
      .load       (load),
      .load_val   (load_val),
      .inc        (inc),
      .dec        (dec),
      .flag_clr   (flag_clr),
      .thresh     (thresh),
      .out        (out),
      .ovf        (ovf),
      .unf        (unf),
      .thresh_hit (thresh_hit)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog expired");
   end

   // Apply the counting rules to the model for the inputs held at this edge
   task automatic model_update();
      int prev;
      int nv;
      int r;
      bit ov;
      bit un;
      for (int i = 0; i < NUM_CH; i++) begin
         prev = m_val[i];
         nv   = prev;
         ov   = 1'b0;
         un   = 1'b0;
         if (srst) begin
            m_val[i] = 0;
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
            m_hit[i] = 1'b0;
         end else begin
            if (clr[i]) begin
               nv = 0;
            end else if (load[i]) begin
               nv = int'(load_val[i*WIDTH +: WIDTH]);
            end else if (inc[i] && !dec[i]) begin
               r = prev + int'(step);
               if (r > MAXV) begin
                  ov = 1'b1;
                  nv = sat_mode ? MAXV : r - (MAXV + 1);
               end else begin
                  nv = r;
               end
            end else if (dec[i] && !inc[i]) begin
               r = prev - int'(step);
               if (r < 0) begin
                  un = 1'b1;
                  nv = sat_mode ? 0 : r + (MAXV + 1);
               end else begin
                  nv = r;
               end
            end
            m_ovf[i] = ov | (m_ovf[i] & !flag_clr[i]);
            m_unf[i] = un | (m_unf[i] & !flag_clr[i]);
`ifdef COUNTER_BANK_THRESH_EN
            m_hit[i] = (prev < int'(thresh)) && (nv >= int'(thresh));
`else
            m_hit[i] = 1'b0;
`endif
            m_val[i] = nv;
         end
      end
   endtask

   // Clock the current inputs in, update the model, sample 1 unit later
   task automatic applyStimulus();
      @(posedge aclk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      srst     = 1'b0;
      clr      = '0;
      load     = '0;
      inc      = '0;
      dec      = '0;
      flag_clr = '0;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      idle_inputs();
      srst     = 1'b1;
      inc      = 4'hF;
      step     = 4'd1;
      for (int c = 0; c < 2; c++) begin
         applyStimulus();
         n_checks++;
         if (out !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_out: got %h expected 0", out);
         end
         n_checks++;
         if (ovf !== '0 || unf !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_flags: got ovf=%b unf=%b expected 0", ovf, unf);
         end
         n_checks++;
         if (thresh_hit !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_hit: got %b expected 0", thresh_hit);
         end
      end
      idle_inputs();
   endtask

   task automatic test_wrap_overflow();
      $display("[TB] test_wrap_overflow");
      sat_mode = 1'b0;
      load_val[0 +: WIDTH] = 8'hFE;
      load[0] = 1'b1;
      applyStimulus();
      idle_inputs();
      step   = 4'd3;
      inc[0] = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (out[0 +: WIDTH] !== 8'h01) begin
         n_errors++;
         $display("[TB] FAIL wrap_value: got %h expected 01", out[0 +: WIDTH]);
      end
      n_checks++;
      if (ovf[0] !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL wrap_ovf: got %b expected 1", ovf[0]);
      end
      for (int c = 0; c < 5; c++) begin
         applyStimulus();
         n_checks++;
         if (ovf[0] !== 1'b1 || out[0 +: WIDTH] !== 8'h01) begin
            n_errors++;
            $display("[TB] FAIL ovf_sticky: got ovf=%b out=%h expected 1/01", ovf[0], out[0 +: WIDTH]);
         end
      end
      flag_clr[0] = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (ovf[0] !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL ovf_clear: got %b expected 0", ovf[0]);
      end
   endtask

   task automatic test_saturate_underflow();
      $display("[TB] test_saturate_underflow");
      sat_mode = 1'b1;
      load_val[1*WIDTH +: WIDTH] = 8'h02;
      load[1] = 1'b1;
      applyStimulus();
      idle_inputs();
      step   = 4'd5;
      dec[1] = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (out[1*WIDTH +: WIDTH] !== 8'h00 || unf[1] !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL sat_underflow: got out=%h unf=%b expected 00/1", out[1*WIDTH +: WIDTH], unf[1]);
      end
      load[1]     = 1'b1;
      flag_clr[1] = 1'b1;
      applyStimulus();
      idle_inputs();
      step   = 4'd2;
      dec[1] = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (out[1*WIDTH +: WIDTH] !== 8'h00 || unf[1] !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL sat_exact_zero: got out=%h unf=%b expected 00/0", out[1*WIDTH +: WIDTH], unf[1]);
      end
      // Saturate at the top: FD + 5 clamps to FF with ovf
      load_val[1*WIDTH +: WIDTH] = 8'hFD;
      load[1] = 1'b1;
      applyStimulus();
      idle_inputs();
      step   = 4'd5;
      inc[1] = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (out[1*WIDTH +: WIDTH] !== 8'hFF || ovf[1] !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL sat_overflow: got out=%h ovf=%b expected FF/1", out[1*WIDTH +: WIDTH], ovf[1]);
      end
      sat_mode = 1'b0;
   endtask

   task automatic test_priority();
      $display("[TB] test_priority");
      load_val[2*WIDTH +: WIDTH] = 8'h33;
      load[2] = 1'b1;
      applyStimulus();
      idle_inputs();
      step   = 4'd4;
      inc[2] = 1'b1;
      dec[2] = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (out[2*WIDTH +: WIDTH] !== 8'h33) begin
         n_errors++;
         $display("[TB] FAIL inc_dec_hold: got %h expected 33", out[2*WIDTH +: WIDTH]);
      end
      load_val[2*WIDTH +: WIDTH] = 8'h55;
      clr[2]  = 1'b1;
      load[2] = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (out[2*WIDTH +: WIDTH] !== 8'h00) begin
         n_errors++;
         $display("[TB] FAIL clr_over_load: got %h expected 00", out[2*WIDTH +: WIDTH]);
      end
      load[2] = 1'b1;
      inc[2]  = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (out[2*WIDTH +: WIDTH] !== 8'h55) begin
         n_errors++;
         $display("[TB] FAIL load_over_inc: got %h expected 55", out[2*WIDTH +: WIDTH]);
      end
   endtask

   task automatic test_flag_set_wins();
      logic [WIDTH-1:0] expv;
      $display("[TB] test_flag_set_wins");
      sat_mode = 1'b0;
      load_val[3*WIDTH +: WIDTH] = 8'hFF;
      load[3] = 1'b1;
      applyStimulus();
      idle_inputs();
      step        = 4'd1;
      inc[3]      = 1'b1;
      flag_clr[3] = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (ovf[3] !== 1'b1 || out[3*WIDTH +: WIDTH] !== 8'h00) begin
         n_errors++;
         $display("[TB] FAIL set_beats_clear: got ovf=%b out=%h expected 1/00", ovf[3], out[3*WIDTH +: WIDTH]);
      end
      for (int i = 0; i < 3; i++) begin
         expv = m_val[i][WIDTH-1:0];
         n_checks++;
         if (out[i*WIDTH +: WIDTH] !== expv || ovf[i] !== m_ovf[i] || unf[i] !== m_unf[i]) begin
            n_errors++;
            $display("[TB] FAIL other_ch%0d: got out=%h ovf=%b unf=%b expected %h/%b/%b",
                     i, out[i*WIDTH +: WIDTH], ovf[i], unf[i], expv, m_ovf[i], m_unf[i]);
         end
      end
   endtask

   task automatic test_thresh();
      $display("[TB] test_thresh");
      thresh = 8'h10;
      load_val[0 +: WIDTH] = 8'h0E;
      load[0] = 1'b1;
      applyStimulus();
      idle_inputs();
      step   = 4'd2;
      inc[0] = 1'b1;
      applyStimulus();
      idle_inputs();
`ifdef COUNTER_BANK_THRESH_EN
      n_checks++;
      if (thresh_hit[0] !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL thresh_pulse: got %b expected 1", thresh_hit[0]);
      end
`else
      n_checks++;
      if (thresh_hit !== '0) begin
         n_errors++;
         $display("[TB] FAIL thresh_tied: got %b expected 0", thresh_hit);
      end
`endif
      applyStimulus();
      n_checks++;
      if (thresh_hit[0] !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL thresh_one_cycle: got %b expected 0", thresh_hit[0]);
      end
      inc[0] = 1'b1;
      applyStimulus();
      idle_inputs();
      n_checks++;
      if (thresh_hit[0] !== 1'b0 || out[0 +: WIDTH] !== 8'h12) begin
         n_errors++;
         $display("[TB] FAIL thresh_no_repulse: got hit=%b out=%h expected 0/12", thresh_hit[0], out[0 +: WIDTH]);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] expv;
      $display("[TB] test_back_to_back");
      sat_mode = 1'b0;
      step     = 4'd7;
      for (int c = 0; c < 40; c++) begin
         inc = 4'b0101;
         dec = 4'b1010;
         applyStimulus();
         for (int i = 0; i < NUM_CH; i++) begin
            expv = m_val[i][WIDTH-1:0];
            n_checks++;
            if (out[i*WIDTH +: WIDTH] !== expv || ovf[i] !== m_ovf[i] || unf[i] !== m_unf[i]) begin
               n_errors++;
               $display("[TB] FAIL b2b_ch%0d cycle %0d: got out=%h ovf=%b unf=%b expected %h/%b/%b",
                        i, c, out[i*WIDTH +: WIDTH], ovf[i], unf[i], expv, m_ovf[i], m_unf[i]);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] expv;
      $display("[TB] test_random");
      for (int c = 0; c < 600; c++) begin
         srst     = ($urandom_range(63) == 0);
         sat_mode = 1'($urandom_range(1));
         step     = STEP_W'($urandom);
         thresh   = WIDTH'($urandom);
         load_val = NUM_CH*WIDTH'($urandom);
         for (int i = 0; i < NUM_CH; i++) begin
            clr[i]      = ($urandom_range(15) == 0);
            load[i]     = ($urandom_range(9) == 0);
            inc[i]      = ($urandom_range(2) != 0);
            dec[i]      = ($urandom_range(2) == 0);
            flag_clr[i] = ($urandom_range(7) == 0);
         end
         applyStimulus();
         for (int i = 0; i < NUM_CH; i++) begin
            expv = m_val[i][WIDTH-1:0];
            n_checks++;
            if (out[i*WIDTH +: WIDTH] !== expv) begin
               n_errors++;
               $display("[TB] FAIL rand_out ch%0d cycle %0d: got %h expected %h", i, c, out[i*WIDTH +: WIDTH], expv);
            end
            n_checks++;
            if (ovf[i] !== m_ovf[i] || unf[i] !== m_unf[i]) begin
               n_errors++;
               $display("[TB] FAIL rand_flags ch%0d cycle %0d: got ovf=%b unf=%b expected %b/%b",
                        i, c, ovf[i], unf[i], m_ovf[i], m_unf[i]);
            end
            n_checks++;
            if (thresh_hit[i] !== m_hit[i]) begin
               n_errors++;
               $display("[TB] FAIL rand_hit ch%0d cycle %0d: got %b expected %b", i, c, thresh_hit[i], m_hit[i]);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      srst     = 1'b0;
      sat_mode = 1'b0;
      step     = '0;
      clr      = '0;
      load     = '0;
      load_val = '0;
      inc      = '0;
      dec      = '0;
      flag_clr = '0;
      thresh   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_val[i] = 0;
         m_ovf[i] = 1'b0;
         m_unf[i] = 1'b0;
         m_hit[i] = 1'b0;
      end
      #1;
      test_reset();
      test_wrap_overflow();
      test_saturate_underflow();
      test_priority();
      test_flag_set_wins();
      test_thresh();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
